// File: rtl/hough_transform.sv
// -----------------------------------------------------------------------------
// hough_transform
//   Hough line detector for a binary edge map. Each accepted edge pixel votes
//   into one rho bin of every theta bank. Once a frame has been quiet for
//   IDLE_CYCLES cycles, the accumulator is scanned one cell per cycle,
//   theta-major and bin-minor. Local peaks along rho are reported, and each
//   visited cell is cleared ready for the next frame.
//
// Ports
//   clk          : sole clock, rising edge
//   rst          : synchronous active-high reset
//   pixel_in     : edge bit, votes only when 1
//   pixel_valid  : qualifies pixel_in / pixel_x / pixel_y this cycle
//   pixel_x      : column (10 bits)
//   pixel_y      : row (10 bits)
//   frame_start  : one-cycle pulse opening a frame
//   line_valid   : one-cycle strobe, line_* hold a detected line
//   line_rho     : signed rho in pixels = bin*RHO_RESOLUTION - MAX_RHO
//   line_theta   : theta in degrees
//   line_votes   : vote count of the reported peak
// -----------------------------------------------------------------------------
module hough_transform #(
    parameter int IMG_WIDTH        = 640,
    parameter int IMG_HEIGHT       = 480,
    parameter int RHO_RESOLUTION   = 4,
    parameter int THETA_STEPS      = 45,
    parameter int ACCUMULATOR_BITS = 12,
    parameter int MIN_VOTES        = 100,
    parameter int IDLE_CYCLES      = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pixel_in,
    input  logic                        pixel_valid,
    input  logic [9:0]                  pixel_x,
    input  logic [9:0]                  pixel_y,
    input  logic                        frame_start,
    output logic                        line_valid,
    output logic [15:0]                 line_rho,
    output logic [7:0]                  line_theta,
    output logic [ACCUMULATOR_BITS-1:0] line_votes
);

    function automatic int isqrt(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    localparam int MAX_RHO   = isqrt(IMG_WIDTH * IMG_WIDTH + IMG_HEIGHT * IMG_HEIGHT);
    localparam int NBINS     = 2 * MAX_RHO / RHO_RESOLUTION + 1;
    localparam int BIN_W     = $clog2(NBINS);
    localparam int K_W       = $clog2(THETA_STEPS);
    localparam int CNT_W     = $clog2(IDLE_CYCLES);
    localparam int THETA_DEG = 180 / THETA_STEPS;

    localparam logic [BIN_W-1:0]            LAST_BIN = BIN_W'(NBINS - 1);
    localparam logic [K_W-1:0]              LAST_K   = K_W'(THETA_STEPS - 1);
    localparam logic [ACCUMULATOR_BITS-1:0] ACC_MAX  = '1;
    localparam logic [ACCUMULATOR_BITS-1:0] MIN_V    = ACCUMULATOR_BITS'(MIN_VOTES);

    // round(cos(d deg) * 2^14) for even d in 0..90. Every sine and cosine on a
    // 4-degree theta grid folds onto this quarter-wave table.
    function automatic logic signed [15:0] cos_even(input int d);
        case (d)
            0:  return 16'sd16384;  2:  return 16'sd16374;  4:  return 16'sd16344;
            6:  return 16'sd16294;  8:  return 16'sd16225;  10: return 16'sd16135;
            12: return 16'sd16026;  14: return 16'sd15897;  16: return 16'sd15749;
            18: return 16'sd15582;  20: return 16'sd15396;  22: return 16'sd15191;
            24: return 16'sd14968;  26: return 16'sd14726;  28: return 16'sd14466;
            30: return 16'sd14189;  32: return 16'sd13894;  34: return 16'sd13583;
            36: return 16'sd13255;  38: return 16'sd12911;  40: return 16'sd12551;
            42: return 16'sd12176;  44: return 16'sd11786;  46: return 16'sd11381;
            48: return 16'sd10963;  50: return 16'sd10531;  52: return 16'sd10087;
            54: return 16'sd9630;   56: return 16'sd9162;   58: return 16'sd8682;
            60: return 16'sd8192;   62: return 16'sd7692;   64: return 16'sd7182;
            66: return 16'sd6664;   68: return 16'sd6138;   70: return 16'sd5604;
            72: return 16'sd5063;   74: return 16'sd4516;   76: return 16'sd3964;
            78: return 16'sd3406;   80: return 16'sd2845;   82: return 16'sd2280;
            84: return 16'sd1713;   86: return 16'sd1143;   88: return 16'sd572;
            default: return 16'sd0;
        endcase
    endfunction

    function automatic logic signed [15:0] cos_q(input int k);
        int t;
        t = k * THETA_DEG;
        if (t <= 90) return cos_even(t);
        return -cos_even(180 - t);
    endfunction

    function automatic logic signed [15:0] sin_q(input int k);
        int t;
        t = k * THETA_DEG;
        if (t <= 90) return cos_even(90 - t);
        return cos_even(t - 90);
    endfunction

    typedef enum logic [1:0] {IDLE, ACCUM, SCAN} state_e;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            idle_cnt_q, idle_cnt_d;
    logic [K_W-1:0]              scan_k_q, scan_k_d;
    logic [BIN_W-1:0]            scan_b_q, scan_b_d;
    logic [ACCUMULATOR_BITS-1:0] prev_q, prev_d;
    logic                        line_valid_q, line_valid_d;
    logic [15:0]                 line_rho_q, line_rho_d;
    logic [7:0]                  line_theta_q, line_theta_d;
    logic [ACCUMULATOR_BITS-1:0] line_votes_q, line_votes_d;

    logic [ACCUMULATOR_BITS-1:0] acc_q [THETA_STEPS][NBINS];

    // ---------------------------------------------------------------- pipeline
    logic              accept;
    logic              v1_q, v2_q;
    logic [9:0]        x1_q, y1_q;
    logic signed [31:0] x1_s, y1_s;
    logic signed [31:0] rho_c [THETA_STEPS];
    logic [BIN_W-1:0]  bin_d  [THETA_STEPS];
    logic [BIN_W-1:0]  bin2_q [THETA_STEPS];

    assign accept = pixel_valid && pixel_in && (state_q == ACCUM)
                 && (int'(pixel_x) < IMG_WIDTH) && (int'(pixel_y) < IMG_HEIGHT);
    assign x1_s = signed'(32'(x1_q));
    assign y1_s = signed'(32'(y1_q));

    always_comb begin
        for (int k = 0; k < THETA_STEPS; k++) begin
            rho_c[k] = (x1_s * 32'(cos_q(k)) + y1_s * 32'(sin_q(k)) + 32'sd8192) >>> 14;
            bin_d[k] = BIN_W'((rho_c[k] + MAX_RHO) / RHO_RESOLUTION);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            x1_q <= '0;
            y1_q <= '0;
            for (int k = 0; k < THETA_STEPS; k++) bin2_q[k] <= '0;
        end else begin
            v1_q <= accept;
            v2_q <= v1_q;
            x1_q <= pixel_x;
            y1_q <= pixel_y;
            for (int k = 0; k < THETA_STEPS; k++) bin2_q[k] <= bin_d[k];
        end
    end

    // ------------------------------------------------------------- accumulator
    // NOTE: the accumulator is a flop array rather than a RAM, because it must
    // clear completely in the single reset cycle and every bank needs a
    // same-cycle read-modify-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < THETA_STEPS; k++)
                for (int b = 0; b < NBINS; b++) acc_q[k][b] <= '0;
        end else begin
            if (v2_q) begin
                for (int k = 0; k < THETA_STEPS; k++)
                    if (acc_q[k][bin2_q[k]] != ACC_MAX)
                        acc_q[k][bin2_q[k]] <= acc_q[k][bin2_q[k]] + 1'b1;
            end
            if (state_q == SCAN) acc_q[scan_k_q][scan_b_q] <= '0;
        end
    end

    // -------------------------------------------------------------------- scan
    // The left neighbour has already been cleared, so its pre-clear value is
    // carried in prev_q. prev_q is zero at bin 0 of every theta.
    logic [BIN_W-1:0]            scan_b_r;
    logic [ACCUMULATOR_BITS-1:0] cell_c, right_c;
    logic                        peak;

    assign scan_b_r = (scan_b_q == LAST_BIN) ? scan_b_q : scan_b_q + 1'b1;
    assign cell_c   = acc_q[scan_k_q][scan_b_q];
    assign right_c  = (scan_b_q == LAST_BIN) ? '0 : acc_q[scan_k_q][scan_b_r];
    assign peak     = (cell_c >= MIN_V) && (cell_c > prev_q) && (cell_c >= right_c);

    // NOTE: every always_comb output takes a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        idle_cnt_d   = idle_cnt_q;
        scan_k_d     = scan_k_q;
        scan_b_d     = scan_b_q;
        prev_d       = prev_q;
        line_valid_d = 1'b0;
        line_rho_d   = line_rho_q;
        line_theta_d = line_theta_q;
        line_votes_d = line_votes_q;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d    = ACCUM;
                    idle_cnt_d = '0;
                end
            end
            ACCUM: begin
                if (accept || frame_start) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == CNT_W'(IDLE_CYCLES - 1)) begin
                    idle_cnt_d = '0;
                    state_d    = SCAN;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            SCAN: begin
                if (peak) begin
                    line_valid_d = 1'b1;
                    line_rho_d   = 16'(int'(scan_b_q) * RHO_RESOLUTION - MAX_RHO);
                    line_theta_d = 8'(int'(scan_k_q) * THETA_DEG);
                    line_votes_d = cell_c;
                end
                if (scan_b_q == LAST_BIN) begin
                    prev_d   = '0;
                    scan_b_d = '0;
                    if (scan_k_q == LAST_K) begin
                        scan_k_d = '0;
                        state_d  = IDLE;
                    end else begin
                        scan_k_d = scan_k_q + 1'b1;
                    end
                end else begin
                    prev_d   = cell_c;
                    scan_b_d = scan_b_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idle_cnt_q   <= '0;
            scan_k_q     <= '0;
            scan_b_q     <= '0;
            prev_q       <= '0;
            line_valid_q <= 1'b0;
            line_rho_q   <= '0;
            line_theta_q <= '0;
            line_votes_q <= '0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            scan_k_q     <= scan_k_d;
            scan_b_q     <= scan_b_d;
            prev_q       <= prev_d;
            line_valid_q <= line_valid_d;
            line_rho_q   <= line_rho_d;
            line_theta_q <= line_theta_d;
            line_votes_q <= line_votes_d;
        end
    end

    assign line_valid = line_valid_q;
    assign line_rho   = line_rho_q;
    assign line_theta = line_theta_q;
    assign line_votes = line_votes_q;

endmodule

// File: tb/tb_hough_transform.sv
// -----------------------------------------------------------------------------
// tb_hough_transform
//   Drives three frames into hough_transform: a vertical line, a horizontal
//   line with junk pixels, and a diagonal with noise plus a saturating cell.
//   Reported lines are compared with a floating-point-trig reference model.
// -----------------------------------------------------------------------------
module tb_hough_transform;

    localparam int NT = 45;
    localparam int NB = 401;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pixel_in = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        frame_start = 1'b0;
    logic        line_valid;
    logic [15:0] line_rho;
    logic [7:0]  line_theta;
    logic [11:0] line_votes;

    always #5 clk = ~clk;

    hough_transform dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start),
        .line_valid  (line_valid),
        .line_rho    (line_rho),
        .line_theta  (line_theta),
        .line_votes  (line_votes)
    );

    typedef struct {
        int theta;
        int rho;
        int votes;
    } line_t;

    line_t got_q[$];
    line_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    model_acc [NT][NB];
    int    cos_t [NT];
    int    sin_t [NT];
    bit    dut_accum = 1'b0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int q14(input real r);
        if (r >= 0.0) return $rtoi(r * 16384.0 + 0.5);
        return -$rtoi(-r * 16384.0 + 0.5);
    endfunction

    // Reference model: one vote per theta, saturating at 4095.
    task automatic model_vote(input int x, input int y);
        for (int k = 0; k < NT; k++) begin
            int s, rho, b;
            s   = x * cos_t[k] + y * sin_t[k] + 8192;
            rho = s >>> 14;
            b   = (rho + 800) / 4;
            if (model_acc[k][b] < 4095) model_acc[k][b]++;
        end
    endtask

    task automatic model_scan();
        exp_q.delete();
        for (int k = 0; k < NT; k++) begin
            for (int b = 0; b < NB; b++) begin
                int c, l, r;
                line_t t;
                c = model_acc[k][b];
                l = (b > 0) ? model_acc[k][b-1] : 0;
                r = (b < NB - 1) ? model_acc[k][b+1] : 0;
                if (c >= 100 && c > l && c >= r) begin
                    t.theta = k * 4;
                    t.rho   = b * 4 - 800;
                    t.votes = c;
                    exp_q.push_back(t);
                end
            end
        end
        for (int k = 0; k < NT; k++)
            for (int b = 0; b < NB; b++) model_acc[k][b] = 0;
    endtask

    always @(negedge clk) begin
        if (line_valid === 1'b1) begin
            line_t t;
            t.theta = int'(line_theta);
            t.rho   = int'($signed(line_rho));
            t.votes = int'(line_votes);
            got_q.push_back(t);
        end
    end

    task automatic send(input bit v, input bit pin, input int x, input int y);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        pixel_valid = v;
        pixel_in    = pin;
        pixel_x     = x[9:0];
        pixel_y     = y[9:0];
        if (dut_accum && v && pin && x < 640 && y < 480) model_vote(x, y);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            frame_start = 1'b0;
            pixel_valid = 1'b0;
            pixel_in    = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        pixel_valid = 1'b0;
        pixel_in    = 1'b0;
    endtask

    // One non-qualifying pixel of a random kind.
    task automatic send_junk();
        case ($urandom_range(3, 0))
            0: send(1'b0, 1'b1, $urandom_range(639, 0), $urandom_range(479, 0));
            1: send(1'b1, 1'b0, $urandom_range(639, 0), $urandom_range(479, 0));
            2: send(1'b1, 1'b1, $urandom_range(1023, 640), $urandom_range(479, 0));
            default: send(1'b1, 1'b1, $urandom_range(639, 0), $urandom_range(1023, 480));
        endcase
    endtask

    // Quiet period, scan with ignored stimulus, then compare with the model.
    task automatic finish_frame(input string tag);
        idle(1000);
        check({tag, "_no_early_report"}, got_q.size(), 0);
        dut_accum = 1'b0;
        idle(2000);
        pulse_start();
        for (int i = 0; i < 200; i++) send(1'b1, 1'b1, 10, 10);
        idle(15950);
        model_scan();
        check({tag, "_line_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_line%0d_theta", tag, i), got_q[i].theta, exp_q[i].theta);
            check($sformatf("%s_line%0d_rho", tag, i), got_q[i].rho, exp_q[i].rho);
            check($sformatf("%s_line%0d_votes", tag, i), got_q[i].votes, exp_q[i].votes);
        end
    endtask

    initial begin
        int xs [640];
        int found, bad;

        for (int k = 0; k < NT; k++) begin
            real a;
            a = real'(k * 4) * 3.14159265358979 / 180.0;
            cos_t[k] = q14($cos(a));
            sin_t[k] = q14($sin(a));
            for (int b = 0; b < NB; b++) model_acc[k][b] = 0;
        end

        // Reset
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_line_valid", line_valid, 0);
        check("rst_line_rho", $signed(line_rho), 0);
        check("rst_line_theta", line_theta, 0);
        check("rst_line_votes", line_votes, 0);

        // Frame A: vertical line x=200
        pulse_start();
        dut_accum = 1'b1;
        for (int y = 0; y < 480; y++) send(1'b1, 1'b1, 200, y);
        finish_frame("A");
        check("A_single_line", got_q.size(), 1);
        if (got_q.size() > 0) begin
            check("A_theta", got_q[0].theta, 0);
            check("A_rho", got_q[0].rho, 200);
            check("A_votes", got_q[0].votes, 480);
        end
        got_q.delete();

        // Frame B: horizontal line y=240 in random order, junk mixed in,
        // a mid-frame frame_start that must keep the votes.
        for (int i = 0; i < 640; i++) xs[i] = i;
        for (int i = 639; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i, 0);
            t = xs[i]; xs[i] = xs[j]; xs[j] = t;
        end
        pulse_start();
        dut_accum = 1'b1;
        for (int i = 0; i < 640; i++) begin
            if (i == 320) begin
                idle(800);
                pulse_start();
                idle(800);
                check("B_restart_holds_accum", got_q.size(), 0);
            end
            send(1'b1, 1'b1, xs[i], 240);
            if ($urandom_range(3, 0) == 0) send_junk();
        end
        for (int i = 0; i < 150; i++) send(1'b1, 1'b0, 50, 50);
        for (int i = 0; i < 150; i++) send(1'b1, 1'b1, 700, 50);
        for (int i = 0; i < 150; i++) send(1'b1, 1'b1, 50, 500);
        finish_frame("B");
        found = 0;
        bad   = 0;
        foreach (got_q[i]) begin
            if ((got_q[i].theta == 88 || got_q[i].theta == 92) && got_q[i].rho >= 236 &&
                got_q[i].rho <= 264 && got_q[i].votes >= 100) found = 1;
            if (got_q[i].theta < 84 || got_q[i].theta > 96) bad++;
        end
        check("B_horizontal_found", found, 1);
        check("B_theta_outside_range", bad, 0);
        got_q.delete();

        // Frame C: 5000 hits on one pixel, then diagonal y=x with noise.
        pulse_start();
        dut_accum = 1'b1;
        for (int i = 0; i < 5000; i++) send(1'b1, 1'b1, 600, 400);
        for (int x = 100; x < 480; x++) begin
            send(1'b1, 1'b1, x, x);
            if ($urandom_range(4, 0) == 0) send_junk();
            if ($urandom_range(3, 0) != 0)
                send(1'b1, 1'b1, $urandom_range(639, 0), $urandom_range(479, 0));
        end
        finish_frame("C");
        found = 0;
        bad   = 0;
        foreach (got_q[i]) begin
            if ((got_q[i].theta == 132 || got_q[i].theta == 136) && got_q[i].rho >= -12 &&
                got_q[i].rho <= 0 && got_q[i].votes >= 100) found = 1;
            if (got_q[i].theta == 0 && got_q[i].rho == 600 && got_q[i].votes == 4095) bad = 1;
        end
        check("C_diagonal_found", found, 1);
        check("C_saturated_cell", bad, 1);
        got_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
